// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NREQ sources each offer one register write to the arbiter.
// valid/ready: a source raises valid with stable addr/data and holds them until it sees ready; transfer = valid & ready.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port; the winning write
// is registered onto wr_* one cycle after its transfer. rr_ptr is exposed for debug.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [1:0]           wr_src,
  output logic [CW-1:0]        conflict_cnt,
  output logic [CW-1:0]        commit_cnt,
  output logic [1:0]           rr_ptr
);

  localparam logic [1:0] LAST = 2'(NREQ - 1);

  logic [NREQ-1:0] grant;
  logic [1:0]      win_idx;
  logic [1:0]      rr_ptr_next;
  logic            xfer;
  logic            commit;
  logic            multi;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  int              scan;
  int              nvalid;

  // Scan starting at rr_ptr; the first valid requester wins. Nothing is granted in reset or stall.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    xfer    = 1'b0;
    scan    = 0;
    if (!stall && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = int'(rr_ptr) + k;
        if (scan >= NREQ) scan = scan - NREQ;
        if (!xfer && wb.req_valid[scan]) begin
          xfer        = 1'b1;
          grant[scan] = 1'b1;
          win_idx     = 2'(scan);
        end
      end
    end
  end

  always_comb begin
    nvalid = 0;
    for (int k = 0; k < NREQ; k++) nvalid = nvalid + int'(wb.req_valid[k]);
  end

  assign multi    = !stall && (nvalid >= 2);
  assign win_addr = wb.req_addr[win_idx*AW +: AW];
  assign win_data = wb.req_data[win_idx*DW +: DW];
  // Writes to $zero complete the handshake but never reach the register file.
  assign commit   = xfer && (win_addr != '0);

  // Next-state: pointer moves past the winner only on a transfer.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (xfer) rr_ptr_next = (win_idx == LAST) ? 2'd0 : win_idx + 2'd1;
  end

  // Output: one-hot ready straight from the grant scan.
  always_comb begin
    wb.req_ready = grant;
  end

  // State register: arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= 2'd0;
    else        rr_ptr <= rr_ptr_next;
  end

  // Registered write port; address/data/source hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 2'd0;
    end else begin
      wr_en <= commit;
      if (commit) begin
        wr_addr <= win_addr;
        wr_data <= win_data;
        wr_src  <= win_idx;
      end
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      commit_cnt   <= '0;
    end else begin
      if (multi && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
      if (commit && (commit_cnt != '1))  commit_cnt   <= commit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for the arbitration and write
// path, plus hand-written sequences for reset, counter saturation and mid-burst reset.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;
  localparam logic [31:0] D1 = 32'h0000_00A1;
  localparam logic [31:0] D2 = 32'h0000_00A2;

  logic clk;
  logic rst_n;
  logic stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_src;
  logic [CW-1:0] conflict_cnt;
  logic [CW-1:0] commit_cnt;
  logic [1:0]    rr_ptr;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .wb           (wb),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_src       (wr_src),
    .conflict_cnt (conflict_cnt),
    .commit_cnt   (commit_cnt),
    .rr_ptr       (rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0;
    logic [2:0]  exp_ready;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
    logic [1:0]  exp_ptr;
    logic [15:0] exp_commit;
    logic [15:0] exp_conflict;
  } vec_t;

  vec_t vecs[$];

  // scoreboard: expected write data of the table stored in order of appearance
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic st, input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
    input logic [4:0] a2, input logic [31:0] d0, input logic [2:0] rdy, input logic en,
    input logic [4:0] ad, input logic [31:0] dt, input logic [1:0] src, input logic [1:0] ptr,
    input logic [15:0] cm, input logic [15:0] cf);
    vec_t r;
    r.stall = st; r.valid = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d0 = d0;
    r.exp_ready = rdy; r.exp_en = en; r.exp_addr = ad; r.exp_data = dt; r.exp_src = src;
    r.exp_ptr = ptr; r.exp_commit = cm; r.exp_conflict = cf;
    return r;
  endfunction

  // driver
  task automatic drive(input logic st, input logic [2:0] v, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d0);
    stall        = st;
    wb.req_valid = v;
    wb.req_addr  = {a2, a1, a0};
    wb.req_data  = {D2, D1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall,valid,a0,a1,a2,d0 | ready,en,addr,data,src,ptr_after,commit,conflict
    vecs.push_back(mkv(0, 3'b001,  8,  0,  0, 32'hDEAD_BEEF, 3'b001, 1,  8, 32'hDEAD_BEEF, 0, 1,  1, 0));
    vecs.push_back(mkv(0, 3'b100,  0,  0, 20, 32'h0,         3'b100, 1, 20, D2,            2, 0,  2, 0));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b001, 1,  9, 32'hA0,        0, 1,  3, 1));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b010, 1, 16, D1,            1, 2,  4, 2));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b100, 1, 31, D2,            2, 0,  5, 3));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b001, 1,  9, 32'hA0,        0, 1,  6, 4));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b010, 1, 16, D1,            1, 2,  7, 5));
    vecs.push_back(mkv(0, 3'b111,  9, 16, 31, 32'hA0,        3'b100, 1, 31, D2,            2, 0,  8, 6));
    vecs.push_back(mkv(0, 3'b000,  0,  0,  0, 32'h0,         3'b000, 0, 31, D2,            2, 0,  8, 6));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(1, 3'b010, 0, 16, 0, 32'h0,        3'b000, 0, 31, D2,            2, 0,  8, 6));
    vecs.push_back(mkv(0, 3'b010,  0, 16,  0, 32'h0,         3'b010, 1, 16, D1,            1, 2,  9, 6));
    vecs.push_back(mkv(0, 3'b001,  0,  0,  0, 32'h1,         3'b001, 0, 16, D1,            1, 1,  9, 6));
    vecs.push_back(mkv(0, 3'b001, 31,  0,  0, 32'hFF,        3'b001, 1, 31, 32'hFF,        0, 1, 10, 6));
    vecs.push_back(mkv(1, 3'b011, 31, 16,  0, 32'hFF,        3'b000, 0, 31, 32'hFF,        0, 1, 10, 6));
    vecs.push_back(mkv(0, 3'b011, 31, 16,  0, 32'hFF,        3'b010, 1, 16, D1,            1, 2, 11, 7));
    vecs.push_back(mkv(0, 3'b001, 31, 16,  0, 32'hFF,        3'b001, 1, 31, 32'hFF,        0, 1, 12, 7));
    vecs.push_back(mkv(0, 3'b110, 31,  5,  5, 32'hFF,        3'b010, 1,  5, D1,            1, 2, 13, 8));
    vecs.push_back(mkv(0, 3'b100, 31,  5,  5, 32'hFF,        3'b100, 1,  5, D2,            2, 0, 14, 8));
    vecs.push_back(mkv(0, 3'b000,  0,  0,  0, 32'h0,         3'b000, 0,  5, D2,            2, 0, 14, 8));
    foreach (vecs[i]) if (vecs[i].exp_en) exp_q.push_back(vecs[i].exp_data);

    // reset with every source requesting
    rst_n = 1'b0;
    drive(0, 3'b111, 1, 2, 3, 32'h11);
    #12;
    check("reset ready", 32'(wb.req_ready), 32'h0);
    check("reset wr_en", 32'(wr_en), 32'h0);
    check("reset commit_cnt", 32'(commit_cnt), 32'h0);
    check("reset conflict_cnt", 32'(conflict_cnt), 32'h0);
    check("reset rr_ptr", 32'(rr_ptr), 32'h0);
    check("reset wr_addr", 32'(wr_addr), 32'h0);
    @(posedge clk);
    #1;
    check("reset held wr_en", 32'(wr_en), 32'h0);
    drive(0, 3'b000, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // table
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0);
      #1;
      check($sformatf("v%0d ready", i), 32'(wb.req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_en));
      check($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d wr_src", i), 32'(wr_src), 32'(vecs[i].exp_src));
      check($sformatf("v%0d rr_ptr", i), 32'(rr_ptr), 32'(vecs[i].exp_ptr));
      check($sformatf("v%0d commit_cnt", i), 32'(commit_cnt), 32'(vecs[i].exp_commit));
      check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vecs[i].exp_conflict));
      if (wr_en) begin
        if (exp_q.size() == 0) check($sformatf("v%0d unexpected write", i), 32'(wr_en), 32'h0);
        else check($sformatf("v%0d wr_data", i), wr_data, exp_q.pop_front());
      end else begin
        check($sformatf("v%0d held wr_data", i), wr_data, vecs[i].exp_data);
      end
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    // commit counter saturation with a continuous single-source burst
    drive(0, 3'b001, 1, 0, 0, 32'h5A);
    for (int k = 1; k <= 65541; k++) begin
      tick();
      if (k == 100) check("burst commit_cnt 100", 32'(commit_cnt), 32'd114);
    end
    check("saturated commit_cnt", 32'(commit_cnt), 32'hFFFF);
    check("burst wr_en", 32'(wr_en), 32'h1);
    check("burst wr_data", wr_data, 32'h5A);
    check("burst conflict_cnt", 32'(conflict_cnt), 32'd8);

    // asynchronous reset between edges in the middle of the burst
    #2 rst_n = 1'b0;
    #1;
    check("async wr_en", 32'(wr_en), 32'h0);
    check("async commit_cnt", 32'(commit_cnt), 32'h0);
    check("async conflict_cnt", 32'(conflict_cnt), 32'h0);
    check("async ready", 32'(wb.req_ready), 32'h0);
    check("async wr_data", wr_data, 32'h0);
    tick();
    check("async held wr_en", 32'(wr_en), 32'h0);
    check("async held rr_ptr", 32'(rr_ptr), 32'h0);
    drive(0, 3'b000, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("post reset wr_en", 32'(wr_en), 32'h0);
    check("post reset commit_cnt", 32'(commit_cnt), 32'h0);

    // first write after reset
    drive(0, 3'b100, 0, 0, 7, 32'h0);
    #1;
    check("post reset ready", 32'(wb.req_ready), 32'h4);
    tick();
    drive(0, 3'b000, 0, 0, 0, 32'h0);
    check("post reset write en", 32'(wr_en), 32'h1);
    check("post reset write addr", 32'(wr_addr), 32'd7);
    check("post reset write src", 32'(wr_src), 32'd2);
    check("post reset write cnt", 32'(commit_cnt), 32'd1);
    tick();
    check("post reset single pulse", 32'(wr_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
